// File: rtl/serial_word_packer_pkg.sv
// rtl/serial_word_packer_pkg.sv - shared control-state type for the serial word packer
package serial_word_packer_pkg;

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } pack_state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// rtl/serial_shift_reg.sv - partial-word shift register, bit counter and EMPTY/FILLING control
// Bit order follows SERIAL_WORD_PACKER_LSB_FIRST_EN (defined: LSB-first, undefined: MSB-first).
module serial_shift_reg
    import serial_word_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          accept,
    input  logic                          bit_in,
    input  logic                          flush,
    output logic [$clog2(DATA_WIDTH)-1:0] count,
    output logic                          complete,
    output logic [DATA_WIDTH-1:0]         word
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    pack_state_t           state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;

    // word is the partial register with the incoming bit merged in; on the
    // completing bit it is the finished output word.
`ifdef SERIAL_WORD_PACKER_LSB_FIRST_EN
    assign word = {bit_in, shift_q[DATA_WIDTH-1:1]};
`else
    assign word = {shift_q[DATA_WIDTH-2:0], bit_in};
`endif

    assign count = count_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        complete = 1'b0;
        // flush outranks an accepted bit, which is simply dropped
        if (flush) begin
            state_d = EMPTY;
            count_d = '0;
            shift_d = '0;
        end else if (accept) begin
            if (count_q == LAST) begin
                complete = 1'b1;
                state_d  = EMPTY;
                count_d  = '0;
                shift_d  = '0;
            end else begin
                state_d = FILLING;
                count_d = count_q + 1'b1;
                shift_d = word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            count_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/serial_word_packer.sv
// rtl/serial_word_packer.sv - serial-to-parallel word packer with valid/ready handshakes
// Define SERIAL_WORD_PACKER_LSB_FIRST_EN for LSB-first assembly; MSB-first otherwise.
module serial_word_packer
    import serial_word_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          flush,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(DATA_WIDTH)-1:0] count
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic                  accept;
    logic                  complete;
    logic [DATA_WIDTH-1:0] word;

    // Only the completing bit must wait for the output slot; earlier bits
    // keep flowing into the partial register while the output is stalled.
    assign din_ready = !reset && !(count == LAST && dout_valid && !dout_ready);
    assign accept    = din_valid && din_ready;

    serial_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
        .bit_in   (din),
        .flush    (flush),
        .count    (count),
        .complete (complete),
        .word     (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (complete) begin
            dout       <= word;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_packer.sv
// tb/tb_serial_word_packer.sv - directed scoreboard bench for serial_word_packer (DATA_WIDTH=8)
module tb_serial_word_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic       flush;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    logic [7:0] mw;
    int         mc;
    logic [7:0] w1;

    serial_word_packer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference assembly: expected word pushed when its last bit is accepted.
    task automatic model_accept(input logic b);
`ifdef SERIAL_WORD_PACKER_LSB_FIRST_EN
        mw = {b, mw[7:1]};
`else
        mw = {mw[6:0], b};
`endif
        mc++;
        if (mc == 8) begin
            sb.push_back(mw);
            mc = 0;
            mw = '0;
        end
    endtask

    task automatic send_bit(input logic b, input bit chk_ready);
        din       = b;
        din_valid = 1'b1;
        @(negedge clk);
        if (chk_ready) check("din_ready_busy", din_ready, 1'b1);
        @(posedge clk);
        model_accept(b);
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && dout_valid && dout_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_underflow observed=%0h expected=none", dout);
            end
            if (sb.size() != 0) check("word", dout, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $error("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] exp29;
        pat = 8'b1011_0101;
`ifdef SERIAL_WORD_PACKER_LSB_FIRST_EN
        exp29 = 8'hAD;
`else
        exp29 = 8'hB5;
`endif
        mw = '0; mc = 0;
        reset = 1'b1; din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_din_ready", din_ready, 1'b0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_dout", dout, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", din_ready, 1'b1);
        @(posedge clk); #1;

        // 1,0,1,1,0,1,0,1 -> fixed pattern word, valid one cycle after bit 8
        for (int i = 7; i >= 0; i--) send_bit(pat[i], 1'b1);
        check("pat_valid", dout_valid, 1'b1);
        check("pat_dout", dout, exp29);
        check("pat_count", count, 3'd0);

        // 16 back-to-back bits, words on consecutive 8-cycle boundaries
        for (int i = 0; i < 16; i++) begin
            send_bit(1'($urandom), 1'b1);
            if (i == 7 || i == 15) check("b2b_valid", dout_valid, 1'b1);
            if (i == 8) check("b2b_gap", dout_valid, 1'b0);
        end
        idle(2);

        // Stalled output: 15 bits in, the 16th waits for the slot
        dout_ready = 1'b0;
        for (int i = 0; i < 15; i++) send_bit(1'($urandom), 1'b1);
        w1 = sb[0];
        din = 1'($urandom); din_valid = 1'b1;
        @(negedge clk);
        check("stall_count", count, 3'd7);
        check("stall_ready", din_ready, 1'b0);
        check("stall_hold", dout, w1);
        @(posedge clk); #1;
        check("stall_count2", count, 3'd7);
        check("stall_valid", dout_valid, 1'b1);
        dout_ready = 1'b1;
        @(negedge clk);
        check("release_ready", din_ready, 1'b1);
        @(posedge clk);
        model_accept(din);
        #1;
        dout_ready = 1'b0; din_valid = 1'b0;
        check("release_valid", dout_valid, 1'b1);
        check("release_dout", dout, sb[0]);
        dout_ready = 1'b1;
        idle(2);

        // Flush at count 5 with a bit offered: bit dropped, clean next word
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b1);
        check("pre_flush_count", count, 3'd5);
        flush = 1'b1; din = 1'b1; din_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        mw = '0; mc = 0;
        check("flush_count", count, 3'd0);
        check("flush_valid", dout_valid, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 1'b1);
        check("post_flush_valid", dout_valid, 1'b1);
        idle(2);

        // Reset mid-word with a stalled output word pending
        dout_ready = 1'b0;
        for (int i = 0; i < 11; i++) send_bit(1'($urandom), 1'b1);
        din_valid = 1'b0;
        check("pre_rst_count", count, 3'd3);
        check("pre_rst_valid", dout_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", din_ready, 1'b0);
        @(posedge clk); #1;
        sb.delete(); mw = '0; mc = 0;
        check("mid_rst_valid", dout_valid, 1'b0);
        check("mid_rst_count", count, 3'd0);
        reset = 1'b0;
        @(negedge clk);
        check("after_rst_ready", din_ready, 1'b1);
        dout_ready = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 1'b1);
        idle(3);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
